param_lfsr: RTL and testbench
=============================

PARAM_LFSR -- requirements
Module: param_lfsr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the register width; legal range 3..16.
REQ-002 The block SHALL have parameter SEED, default 1, meaning the nonzero reset and recovery state.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock; the block has one clock.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port enable  input  1  advances the register one step per cycle when high.
REQ-006 The block SHALL have port load  input  1  loads seed_in on the next edge.
REQ-007 The block SHALL have port seed_in  input  WIDTH  value loaded when load is high.
REQ-008 The block SHALL have port result  output  WIDTH  current register state.
REQ-009 The block SHALL have port count  output  WIDTH  steps taken since the last reset or load, modulo the period.
REQ-010 The block SHALL have port wrap  output  1  one-cycle pulse when the state returns to the active seed.
REQ-011 The block SHALL have port lockup  output  1  one-cycle pulse when an all-zero seed was rejected.

Function
REQ-012 Feedback SHALL be Fibonacci form:
- fb = XOR of state bits selected by TAP_MASK(WIDTH);
- next = {state[WIDTH-2:0], fb}.
REQ-013 TAP_MASK SHALL give a maximal-length polynomial for every legal WIDTH, with period 2^WIDTH-1 (WIDTH=4 mask = 4'b1100, x^4+x^3+1).
REQ-014 Priority SHALL be reset > load > enable; with none active, the state, count and seed register SHALL hold.
REQ-015 On load with seed_in != 0:
- result <= seed_in;
- the active seed register <= seed_in;
- count <= 0.
REQ-016 On load with seed_in == 0:
- result <= SEED;
- the active seed <= SEED;
- count <= 0;
- lockup SHALL be 1 for exactly the following cycle.
REQ-017 On enable (no load), result SHALL advance one step and count SHALL increment in the same edge, so latency is 1 cycle.
REQ-018 When a step makes next equal the active seed:
- count SHALL wrap to 0 rather than incrementing;
- wrap SHALL be 1 during the cycle that result equals the seed after that step.
REQ-019 wrap and lockup SHALL be registered and SHALL be 0 in every cycle not described above.
REQ-020 load and enable asserted together SHALL perform the load only; that edge produces no step and no wrap.
REQ-021 result SHALL never hold all-zero outside X-free simulation errors; the bench asserts this every cycle.
REQ-022 An elaboration-time check SHALL fail if WIDTH is outside 3..16 or SEED == 0 or SEED >= 2^WIDTH.

Reset
REQ-023 On reset:
- result <= SEED;
- the active seed <= SEED;
- count <= 0;
- wrap <= 0;
- lockup <= 0.
REQ-024 Reset asserted mid-sequence SHALL override load and enable on that edge; stepping SHALL resume from SEED the cycle after reset deasserts.

Structure
REQ-025 Package lfsr_pkg SHALL hold:
- the constants LFSR_MIN_WIDTH=3 and LFSR_MAX_WIDTH=16;
- the function tap_mask(width) returning a 16-bit mask table.
REQ-026 Sub-module lfsr_next SHALL be combinational and SHALL compute next state and fb from state and mask; param_lfsr SHALL hold all registers.

Verification
REQ-027 The bench SHALL cover these scenarios (WIDTH=4, SEED=1 unless stated):
- Reset, then enable high for 15 cycles -> result 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8, then 1 again; count 0..14 then 0; wrap high exactly on the return to 1.
- Load seed_in=4'hA, then enable 15 steps -> first result A, then 5,B,7,...; wrap after 15 steps with result=A; count=0 at wrap.
- Load seed_in=0 -> next cycle result=1, lockup=1 for one cycle, count=0.
- load=1 and enable=1 together with seed_in=6 -> result=6, count=0, no step, no wrap.
- After 7 steps (result=10), assert reset for 1 cycle with enable held high -> result=1, count=0; the next edge gives result=2.
- WIDTH=8 and WIDTH=16 -> a full run of 255 or 65535 steps returns to the seed with exactly one wrap pulse and no all-zero state.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and the maximal-length tap table for the Fibonacci LFSR.
// Bit k of a mask selects state[k] as a feedback term.
package lfsr_pkg;

    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 16;

    // Masks come from primitive trinomials/pentanomials; bit n-1 is always set.
    function automatic logic [15:0] tap_mask(input int width);
        logic [15:0] mask;
        mask = 16'h0000;
        case (width)
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational Fibonacci step: feedback is the parity of the masked state bits,
// shifted in at bit 0.
module lfsr_next #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_next,
    output logic             o_fb
);

    logic [WIDTH-1:0] w_terms;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_term
            assign w_terms[gi] = i_state[gi] & i_mask[gi];
        end
    endgenerate

    assign o_fb   = ^w_terms;
    assign o_next = {i_state[WIDTH-2:0], o_fb};

endmodule

// File: rtl/param_lfsr.sv
// Parameterised maximal-length LFSR with loadable seed, step counter and
// wrap/lockup pulses. All state lives here; the step logic is in lfsr_next.
module param_lfsr
    import lfsr_pkg::*;
#(
    parameter int          WIDTH = 4,
    parameter int unsigned SEED  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             lockup
);

    generate
        if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
            $error("param_lfsr: WIDTH out of range");
        end
        if (SEED == 0 || longint'(SEED) >= (64'd1 << WIDTH)) begin : g_bad_seed
            $error("param_lfsr: SEED must be nonzero and fit in WIDTH bits");
        end
    endgenerate

    localparam logic [15:0]      TAP_FULL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAP_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_lockup;

    logic [WIDTH-1:0] w_next;
    logic             w_fb;
    logic             w_hit_seed;
    logic             w_seed_zero;

    lfsr_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_state (r_state),
        .i_mask  (TAPS),
        .o_next  (w_next),
        .o_fb    (w_fb)
    );

    assign w_hit_seed  = (w_next == r_seed);
    assign w_seed_zero = (seed_in == '0);

    // An all-zero seed would freeze the register, so it is replaced by SEED.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= SEED_V;
            r_seed   <= SEED_V;
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
            if (load) begin
                r_state  <= w_seed_zero ? SEED_V : seed_in;
                r_seed   <= w_seed_zero ? SEED_V : seed_in;
                r_count  <= '0;
                r_lockup <= w_seed_zero;
            end else if (enable) begin
                r_state <= w_next;
                r_count <= w_hit_seed ? '0 : r_count + 1'b1;
                r_wrap  <= w_hit_seed;
            end
        end
    end

    assign result = r_state;
    assign count  = r_count;
    assign wrap   = r_wrap;
    assign lockup = r_lockup;

endmodule

// File: tb/tb_param_lfsr.sv
// Self-checking bench for param_lfsr: directed scenarios at WIDTH=4, a randomized
// run against a behavioural model, and full-period runs at WIDTH=8 and WIDTH=16.
module tb_param_lfsr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // WIDTH=4 instance
    logic        rst4, en4, ld4;
    logic [3:0]  sin4, res4, cnt4;
    logic        wrap4, lock4;
    // WIDTH=8 instance
    logic        rst8, en8, ld8;
    logic [7:0]  sin8, res8, cnt8;
    logic        wrap8, lock8;
    // WIDTH=16 instance
    logic        rst16, en16, ld16;
    logic [15:0] sin16, res16, cnt16;
    logic        wrap16, lock16;

    param_lfsr #(.WIDTH(4), .SEED(1)) dut4 (
        .clock(clk), .reset(rst4), .enable(en4), .load(ld4), .seed_in(sin4),
        .result(res4), .count(cnt4), .wrap(wrap4), .lockup(lock4));
    param_lfsr #(.WIDTH(8), .SEED(1)) dut8 (
        .clock(clk), .reset(rst8), .enable(en8), .load(ld8), .seed_in(sin8),
        .result(res8), .count(cnt8), .wrap(wrap8), .lockup(lock8));
    param_lfsr #(.WIDTH(16), .SEED(1)) dut16 (
        .clock(clk), .reset(rst16), .enable(en16), .load(ld16), .seed_in(sin16),
        .result(res16), .count(cnt16), .wrap(wrap16), .lockup(lock16));

    // Polynomial taps written out from the polynomial exponents
    function automatic int poly_mask(int w);
        case (w)
            4:  return (1 << 3) | (1 << 2);                       // x^4+x^3+1
            8:  return (1 << 7) | (1 << 5) | (1 << 4) | (1 << 3); // x^8+x^6+x^5+x^4+1
            16: return (1 << 15) | (1 << 14) | (1 << 12) | (1 << 3); // x^16+x^15+x^13+x^4+1
            default: return 0;
        endcase
    endfunction

    function automatic int model_step(int s, int w);
        int fb;
        fb = $countones(s & poly_mask(w)) % 2;
        return ((s << 1) | fb) & ((1 << w) - 1);
    endfunction

    // Zero-state watchdog on the WIDTH=4 instance once it has been reset
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (res4 == 4'd0) begin
                errors++;
                $display("FAIL nonzero4 t=%0t result=%0d required nonzero", $time, res4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic r, input logic l, input logic e, input logic [3:0] s);
        rst4 = r; ld4 = l; en4 = e; sin4 = s;
    endtask

    task automatic test_reset();
        drive4(1, 0, 0, 0);
        rst8 = 1; rst16 = 1;
        tick();
        checks += 4;
        if (res4 !== 4'd1)  begin errors++; $display("FAIL reset_result got=%0d want=1", res4); end
        if (cnt4 !== 4'd0)  begin errors++; $display("FAIL reset_count got=%0d want=0", cnt4); end
        if (wrap4 !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%0b want=0", wrap4); end
        if (lock4 !== 1'b0) begin errors++; $display("FAIL reset_lockup got=%0b want=0", lock4); end
        drive4(0, 0, 0, 0);
        rst8 = 0; rst16 = 0;
        mon_en = 1'b1;
        $display("test_reset: result=%0d count=%0d", res4, cnt4);
    endtask

    task automatic test_sequence();
        int exp_seq[15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
        for (int i = 0; i < 15; i++) begin
            drive4(0, 0, 1, 0);
            tick();
            checks += 3;
            if (res4 !== 4'(exp_seq[i])) begin errors++; $display("FAIL seq_result step=%0d got=%0d want=%0d", i + 1, res4, exp_seq[i]); end
            if (cnt4 !== 4'((i + 1) % 15)) begin errors++; $display("FAIL seq_count step=%0d got=%0d want=%0d", i + 1, cnt4, (i + 1) % 15); end
            if (wrap4 !== (i == 14)) begin errors++; $display("FAIL seq_wrap step=%0d got=%0b want=%0b", i + 1, wrap4, i == 14); end
        end
        drive4(0, 0, 0, 0);
        tick();
        checks += 2;
        if (wrap4 !== 1'b0) begin errors++; $display("FAIL seq_wrap_drop got=%0b want=0", wrap4); end
        if (res4 !== 4'd1)  begin errors++; $display("FAIL seq_hold got=%0d want=1", res4); end
        $display("test_sequence: 15 steps, final result=%0d", res4);
    endtask

    task automatic test_load_a();
        int st;
        drive4(0, 1, 0, 4'hA);
        tick();
        checks += 3;
        if (res4 !== 4'hA)  begin errors++; $display("FAIL loadA_result got=%0h want=a", res4); end
        if (cnt4 !== 4'd0)  begin errors++; $display("FAIL loadA_count got=%0d want=0", cnt4); end
        if (lock4 !== 1'b0) begin errors++; $display("FAIL loadA_lockup got=%0b want=0", lock4); end
        st = 'hA;
        for (int i = 1; i <= 15; i++) begin
            drive4(0, 0, 1, 0);
            tick();
            st = model_step(st, 4);
            checks += 3;
            if (res4 !== 4'(st)) begin errors++; $display("FAIL loadA_result step=%0d got=%0h want=%0h", i, res4, st); end
            if (cnt4 !== 4'(i % 15)) begin errors++; $display("FAIL loadA_count step=%0d got=%0d want=%0d", i, cnt4, i % 15); end
            if (wrap4 !== (i == 15)) begin errors++; $display("FAIL loadA_wrap step=%0d got=%0b want=%0b", i, wrap4, i == 15); end
            if (i == 1) begin
                checks++;
                if (res4 !== 4'h5) begin errors++; $display("FAIL loadA_first got=%0h want=5", res4); end
            end
        end
        $display("test_load_a: final result=%0h count=%0d wrap=%0b", res4, cnt4, wrap4);
    endtask

    task automatic test_load_zero();
        drive4(0, 0, 1, 0);
        tick();
        drive4(0, 1, 0, 4'h0);
        tick();
        checks += 3;
        if (res4 !== 4'd1)  begin errors++; $display("FAIL zero_result got=%0d want=1", res4); end
        if (lock4 !== 1'b1) begin errors++; $display("FAIL zero_lockup got=%0b want=1", lock4); end
        if (cnt4 !== 4'd0)  begin errors++; $display("FAIL zero_count got=%0d want=0", cnt4); end
        drive4(0, 0, 0, 0);
        tick();
        checks += 2;
        if (lock4 !== 1'b0) begin errors++; $display("FAIL zero_lockup_drop got=%0b want=0", lock4); end
        if (res4 !== 4'd1)  begin errors++; $display("FAIL zero_hold got=%0d want=1", res4); end
        $display("test_load_zero: result=%0d lockup pulse seen", res4);
    endtask

    task automatic test_load_enable();
        drive4(0, 0, 1, 0);
        tick();
        tick();
        drive4(0, 1, 1, 4'd6);
        tick();
        checks += 4;
        if (res4 !== 4'd6)  begin errors++; $display("FAIL ldEn_result got=%0d want=6", res4); end
        if (cnt4 !== 4'd0)  begin errors++; $display("FAIL ldEn_count got=%0d want=0", cnt4); end
        if (wrap4 !== 1'b0) begin errors++; $display("FAIL ldEn_wrap got=%0b want=0", wrap4); end
        if (lock4 !== 1'b0) begin errors++; $display("FAIL ldEn_lockup got=%0b want=0", lock4); end
        $display("test_load_enable: result=%0d count=%0d", res4, cnt4);
    endtask

    task automatic test_reset_mid();
        drive4(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive4(0, 0, 1, 0);
            tick();
        end
        checks++;
        if (res4 !== 4'd10) begin errors++; $display("FAIL mid_pre got=%0d want=10", res4); end
        drive4(1, 1, 1, 4'h7);
        tick();
        checks += 2;
        if (res4 !== 4'd1) begin errors++; $display("FAIL mid_result got=%0d want=1", res4); end
        if (cnt4 !== 4'd0) begin errors++; $display("FAIL mid_count got=%0d want=0", cnt4); end
        drive4(0, 0, 1, 0);
        tick();
        checks += 2;
        if (res4 !== 4'd2) begin errors++; $display("FAIL mid_resume got=%0d want=2", res4); end
        if (cnt4 !== 4'd1) begin errors++; $display("FAIL mid_resume_count got=%0d want=1", cnt4); end
        $display("test_reset_mid: resumed result=%0d", res4);
    endtask

    // Model: state, active seed, and number of steps since reset/load
    task automatic test_random();
        int st = 1, sd = 1, steps = 0;
        bit ew, el;
        logic r, l, e;
        logic [3:0] s;
        drive4(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 29) == 0);
            l = ($urandom_range(0, 5) == 0);
            e = $urandom_range(0, 3) != 0;
            s = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            drive4(r, l, e, s);
            tick();
            ew = 0; el = 0;
            if (r) begin
                st = 1; sd = 1; steps = 0;
            end else if (l) begin
                el = (s == 0);
                st = (s == 0) ? 1 : int'(s);
                sd = st; steps = 0;
            end else if (e) begin
                st = model_step(st, 4);
                steps++;
                ew = (steps % 15 == 0);
            end
            checks += 4;
            if (res4 !== 4'(st))         begin errors++; $display("FAIL rnd_result cyc=%0d got=%0d want=%0d", i, res4, st); end
            if (cnt4 !== 4'(steps % 15)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, cnt4, steps % 15); end
            if (wrap4 !== ew)            begin errors++; $display("FAIL rnd_wrap cyc=%0d got=%0b want=%0b", i, wrap4, ew); end
            if (lock4 !== el)            begin errors++; $display("FAIL rnd_lockup cyc=%0d got=%0b want=%0b", i, lock4, el); end
        end
        drive4(0, 0, 0, 0);
        $display("test_random: 400 cycles, sd=%0d", sd);
    endtask

    task automatic test_full_period();
        int s8 = 1, s16 = 1, wraps8 = 0, wraps16 = 0;
        rst8 = 1; rst16 = 1; en8 = 0; en16 = 0;
        tick();
        rst8 = 0; rst16 = 0;
        for (int i = 1; i <= 65535; i++) begin
            en8 = (i <= 255);
            en16 = 1;
            tick();
            s16 = model_step(s16, 16);
            if (wrap16) wraps16++;
            checks += 2;
            if (res16 !== 16'(s16)) begin errors++; $display("FAIL w16_result step=%0d got=%0h want=%0h", i, res16, s16); end
            if (res16 == 16'd0)     begin errors++; $display("FAIL w16_zero step=%0d got=0", i); end
            if (i <= 255) begin
                s8 = model_step(s8, 8);
                if (wrap8) wraps8++;
                checks += 2;
                if (res8 !== 8'(s8)) begin errors++; $display("FAIL w8_result step=%0d got=%0h want=%0h", i, res8, s8); end
                if (res8 == 8'd0)    begin errors++; $display("FAIL w8_zero step=%0d got=0", i); end
                if (i == 255) begin
                    checks += 3;
                    if (res8 !== 8'd1)  begin errors++; $display("FAIL w8_return got=%0h want=1", res8); end
                    if (cnt8 !== 8'd0)  begin errors++; $display("FAIL w8_count got=%0d want=0", cnt8); end
                    if (wraps8 !== 1)   begin errors++; $display("FAIL w8_wraps got=%0d want=1", wraps8); end
                end
            end
        end
        en16 = 0;
        checks += 3;
        if (res16 !== 16'd1) begin errors++; $display("FAIL w16_return got=%0h want=1", res16); end
        if (cnt16 !== 16'd0) begin errors++; $display("FAIL w16_count got=%0d want=0", cnt16); end
        if (wraps16 !== 1)   begin errors++; $display("FAIL w16_wraps got=%0d want=1", wraps16); end
        $display("test_full_period: w8 wraps=%0d w16 wraps=%0d", wraps8, wraps16);
    endtask

    initial begin
        drive4(1, 0, 0, 0);
        rst8 = 1; en8 = 0; ld8 = 0; sin8 = 0;
        rst16 = 1; en16 = 0; ld16 = 0; sin16 = 0;
        test_reset();
        test_sequence();
        test_load_a();
        test_load_zero();
        test_load_enable();
        test_reset_mid();
        test_random();
        test_full_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
